// File: rtl/instr_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// instr_cycle_ctrl
//
// Instruction-cycle sequencer for the 12-bit-instruction core. Every
// instruction cycle is four clocks (Q1..Q4). The block:
//   - drives the per-phase strobes,
//   - owns the PC and a 2-level call/return stack,
//   - discards (flushes) the prefetched instruction after a taken branch or
//     skip,
//   - parks the core in SLEEP until a wake request arrives.
//
// Pipeline: the instruction fetched in cycle n executes in cycle n+1. While an
// instruction executes, pc_o already points at the next instruction, so a CALL
// pushes pc_o as its return address.
//
// Optional feature (macro STACK_STATUS_EN):
//   when defined, the block adds stk_level_o / stk_err_o. stk_err_o is a sticky
//   flag that sets on an overflowing push or an underflowing pop.
//
// Parameters:
//   PC_W       PC / stack entry width (must be > 8)
//   RESET_VEC  PC value loaded on reset
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   goto_i       in   decoded GOTO of the executing instruction
//   call_i       in   decoded CALL
//   retlw_i      in   decoded RETLW
//   sleep_i      in   decoded SLEEP
//   skip_i       in   skip condition of the executing instruction
//   longk_i      in   literal/target field from the decoder
//   wake_i       in   wake request (level), only looked at while sleeping
//   pc_o         out  program-memory fetch address
//   fetch_en_o   out  Q1 strobe (RUN and FLUSH)
//   decode_ck_o  out  Q2 strobe (RUN and FLUSH)
//   exec_en_o    out  Q3 strobe (RUN only)
//   wb_en_o      out  Q4 strobe (RUN only)
//   flush_o      out  current cycle's instruction is discarded
//   sleeping_o   out  core is in SLEEP
//   dbg_state_o  out  FSM state (0 RUN, 1 FLUSH, 2 SLEEP)
//   dbg_q_o      out  phase counter (0 Q1 .. 3 Q4)
//   stk_level_o  out  stack depth 0..2          (STACK_STATUS_EN only)
//   stk_err_o    out  sticky over/underflow     (STACK_STATUS_EN only)
// -----------------------------------------------------------------------------
module instr_cycle_ctrl #(
  parameter int               PC_W      = 9,
  parameter logic [PC_W-1:0]  RESET_VEC = 9'h1FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            goto_i,
  input  logic            call_i,
  input  logic            retlw_i,
  input  logic            sleep_i,
  input  logic            skip_i,
  input  logic [PC_W-1:0] longk_i,
  input  logic            wake_i,
  output logic [PC_W-1:0] pc_o,
  output logic            fetch_en_o,
  output logic            decode_ck_o,
  output logic            exec_en_o,
  output logic            wb_en_o,
  output logic            flush_o,
  output logic            sleeping_o,
  output logic [1:0]      dbg_state_o,
  output logic [1:0]      dbg_q_o
`ifdef STACK_STATUS_EN
  ,
  output logic [1:0]      stk_level_o,
  output logic            stk_err_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } phase_t;

  state_t          r_state;
  phase_t          r_q;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_stk0;
  logic [PC_W-1:0] r_stk1;
  logic [1:0]      r_level;

  logic            r_fetch_en;
  logic            r_decode_ck;
  logic            r_exec_en;
  logic            r_wb_en;
  logic            r_flush;
  logic            r_sleeping;

  state_t          w_state_nxt;
  phase_t          w_q_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_push;
  logic            w_pop;

  // Natural PC_W-bit wrap: all-ones + 1 -> 0.
  assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  // Next-state logic. Control inputs matter only at Q4 of a RUN cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        w_q_nxt = phase_t'(r_q + 2'd1);
        if (r_q == Q4) begin
          if (retlw_i) begin
            w_pop       = 1'b1;
            w_pc_nxt    = r_stk0;
            w_state_nxt = ST_FLUSH;
          end else if (call_i) begin
            // CALL reaches only the lower 256 words; upper bits are cleared.
            w_push      = 1'b1;
            w_pc_nxt    = {{(PC_W-8){1'b0}}, longk_i[7:0]};
            w_state_nxt = ST_FLUSH;
          end else if (goto_i) begin
            w_pc_nxt    = longk_i;
            w_state_nxt = ST_FLUSH;
          end else if (skip_i) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_FLUSH;
          end else if (sleep_i) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_SLEEP;
          end else begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        w_q_nxt = phase_t'(r_q + 2'd1);
        if (r_q == Q4) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_RUN;
        end
      end
      ST_SLEEP: begin
        // Phase is parked at Q1 so wake-up resumes on a cycle boundary.
        w_q_nxt = Q1;
        if (wake_i) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_FLUSH;
        w_q_nxt     = Q1;
      end
    endcase
  end

  // State, PC, stack and registered strobes. Strobes are computed from the
  // next phase/state, so they line up with the phase they describe and
  // hold their reset values (all low) until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FLUSH;
      r_q         <= Q1;
      r_pc        <= RESET_VEC;
      r_stk0      <= '0;
      r_stk1      <= '0;
      r_level     <= 2'd0;
      r_fetch_en  <= 1'b0;
      r_decode_ck <= 1'b0;
      r_exec_en   <= 1'b0;
      r_wb_en     <= 1'b0;
      r_flush     <= 1'b1;
      r_sleeping  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_pc    <= w_pc_nxt;

      if (w_push) begin
        // A push at full depth silently drops the oldest entry.
        r_stk1  <= r_stk0;
        r_stk0  <= r_pc;
        r_level <= (r_level == 2'd2) ? 2'd2 : r_level + 2'd1;
      end else if (w_pop) begin
        // stack[1] is left as is, so an empty-stack pop repeats it.
        r_stk0  <= r_stk1;
        r_level <= (r_level == 2'd0) ? 2'd0 : r_level - 2'd1;
      end

      r_fetch_en  <= (w_state_nxt != ST_SLEEP) && (w_q_nxt == Q1);
      r_decode_ck <= (w_state_nxt != ST_SLEEP) && (w_q_nxt == Q2);
      r_exec_en   <= (w_state_nxt == ST_RUN)   && (w_q_nxt == Q3);
      r_wb_en     <= (w_state_nxt == ST_RUN)   && (w_q_nxt == Q4);
      r_flush     <= (w_state_nxt == ST_FLUSH);
      r_sleeping  <= (w_state_nxt == ST_SLEEP);
    end
  end

  assign pc_o        = r_pc;
  assign fetch_en_o  = r_fetch_en;
  assign decode_ck_o = r_decode_ck;
  assign exec_en_o   = r_exec_en;
  assign wb_en_o     = r_wb_en;
  assign flush_o     = r_flush;
  assign sleeping_o  = r_sleeping;
  assign dbg_state_o = r_state;
  assign dbg_q_o     = r_q;

`ifdef STACK_STATUS_EN
  logic r_stk_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stk_err <= 1'b0;
    end else if ((w_push && (r_level == 2'd2)) || (w_pop && (r_level == 2'd0))) begin
      r_stk_err <= 1'b1;
    end
  end

  assign stk_level_o = r_level;
  assign stk_err_o   = r_stk_err;
`endif

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instr_cycle_ctrl
//
// Self-checking bench for instr_cycle_ctrl. Each observation packs
// {pc_o, fetch, decode, exec, wb, flush, sleeping} into one word that is
// compared against an expected word taken from exp_q. Expected words come from
// a directed vector table, hand-written sequences, or a cycle-level reference
// model that works in whole instruction cycles.
// -----------------------------------------------------------------------------
module tb_instr_cycle_ctrl;

  localparam int PC_W   = 9;
  localparam int W      = PC_W + 6;
  localparam int PC_MOD = 1 << PC_W;
  localparam int M_RUN   = 0;
  localparam int M_FLUSH = 1;
  localparam int M_SLEEP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            goto_i = 1'b0;
  logic            call_i = 1'b0;
  logic            retlw_i = 1'b0;
  logic            sleep_i = 1'b0;
  logic            skip_i = 1'b0;
  logic [PC_W-1:0] longk_i = '0;
  logic            wake_i = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            fetch_en_o, decode_ck_o, exec_en_o, wb_en_o, flush_o, sleeping_o;
  logic [1:0]      dbg_state_o, dbg_q_o;
`ifdef STACK_STATUS_EN
  logic [1:0]      stk_level_o;
  logic            stk_err_o;
`endif

  instr_cycle_ctrl #(.PC_W(PC_W), .RESET_VEC(9'h1FF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .goto_i      (goto_i),
    .call_i      (call_i),
    .retlw_i     (retlw_i),
    .sleep_i     (sleep_i),
    .skip_i      (skip_i),
    .longk_i     (longk_i),
    .wake_i      (wake_i),
    .pc_o        (pc_o),
    .fetch_en_o  (fetch_en_o),
    .decode_ck_o (decode_ck_o),
    .exec_en_o   (exec_en_o),
    .wb_en_o     (wb_en_o),
    .flush_o     (flush_o),
    .sleeping_o  (sleeping_o),
    .dbg_state_o (dbg_state_o),
    .dbg_q_o     (dbg_q_o)
`ifdef STACK_STATUS_EN
    ,
    .stk_level_o (stk_level_o),
    .stk_err_o   (stk_err_o)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {pc_o, fetch_en_o, decode_ck_o, exec_en_o, wb_en_o, flush_o, sleeping_o};

  typedef struct {
    logic            g, c, r, s, k, wk;
    logic [PC_W-1:0] lk;
  } ctl_t;

  typedef struct {
    ctl_t            ctl;
    logic [PC_W-1:0] exp_pc;
    int              exp_mode;
  } vec_t;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit fresh    = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got pc=%h strobes(f,d,e,w,fl,sl)=%b, expected pc=%h strobes=%b",
                  name, act[W-1:6], act[5:0], exp[W-1:6], exp[5:0]);
  endtask

  // Expected observation for one phase of a cycle in the given mode.
  // 'first' marks Q1 right after reset release, where fetch has not yet pulsed.
  function automatic logic [W-1:0] exp_word(logic [PC_W-1:0] pc, int mode, int ph, bit first);
    logic f, d, e, w, fl;
    if (mode == M_SLEEP) return {pc, 6'b000001};
    f  = (ph == 0) && !first;
    d  = (ph == 1);
    e  = (ph == 2) && (mode == M_RUN);
    w  = (ph == 3) && (mode == M_RUN);
    fl = (mode == M_FLUSH);
    return {pc, f, d, e, w, fl, 1'b0};
  endfunction

  function automatic ctl_t mkc(logic g, c, r, s, k, logic [PC_W-1:0] lk);
    ctl_t x;
    x.g = g; x.c = c; x.r = r; x.s = s; x.k = k; x.wk = 1'b0; x.lk = lk;
    return x;
  endfunction

  function automatic vec_t mkv(logic g, c, r, s, k, logic [PC_W-1:0] lk,
                               logic [PC_W-1:0] pc, int mode);
    vec_t v;
    v.ctl = mkc(g, c, r, s, k, lk);
    v.exp_pc = pc;
    v.exp_mode = mode;
    return v;
  endfunction

  // ---------------- reference model (one step per instruction cycle) ----------------
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stk[2];
  int              m_mode;
  int              m_level;
  bit              m_err;

  function automatic logic [PC_W-1:0] inc(logic [PC_W-1:0] p);
    return PC_W'((int'(p) + 1) % PC_MOD);
  endfunction

  task automatic model_init();
    m_pc = 9'h1FF; m_mode = M_FLUSH; m_stk[0] = '0; m_stk[1] = '0; m_level = 0; m_err = 0;
  endtask

  task automatic model_step(input ctl_t c);
    if (m_mode == M_FLUSH) begin
      m_pc = inc(m_pc); m_mode = M_RUN;
    end else if (c.r) begin
      if (m_level == 0) m_err = 1; else m_level--;
      m_pc = m_stk[0]; m_stk[0] = m_stk[1]; m_mode = M_FLUSH;
    end else if (c.c) begin
      if (m_level == 2) m_err = 1; else m_level++;
      m_stk[1] = m_stk[0]; m_stk[0] = m_pc;
      m_pc = PC_W'(int'(c.lk) % 256); m_mode = M_FLUSH;
    end else if (c.g) begin
      m_pc = c.lk; m_mode = M_FLUSH;
    end else if (c.k) begin
      m_pc = inc(m_pc); m_mode = M_FLUSH;
    end else if (c.s) begin
      m_pc = inc(m_pc); m_mode = M_SLEEP;
    end else begin
      m_pc = inc(m_pc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    goto_i = 0; call_i = 0; retlw_i = 0; sleep_i = 0; skip_i = 0; wake_i = 0; longk_i = '0;
  endtask

  // Runs one 4-clock instruction cycle from a Q1 negedge, checking every phase.
  task automatic do_cycle(input ctl_t c, input logic [PC_W-1:0] epc, input int emode,
                          input string name);
    goto_i = c.g; call_i = c.c; retlw_i = c.r; sleep_i = c.s; skip_i = c.k;
    wake_i = c.wk; longk_i = c.lk;
    for (int p = 0; p < 4; p++) exp_q.push_back(exp_word(epc, emode, p, fresh && (p == 0)));
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s.q%0d", name, p + 1), obs, exp_q.pop_front());
      @(negedge clk);
    end
    fresh = 1'b0;
    clear_inputs();
  endtask

  // One clock spent in SLEEP; wk drives the wake request for the next edge.
  task automatic sleep_clock(input logic [PC_W-1:0] epc, input bit wk, input string name);
    exp_q.push_back(exp_word(epc, M_SLEEP, 0, 1'b0));
    check(name, obs, exp_q.pop_front());
    goto_i = 1'b1; skip_i = 1'b1;    // must be ignored while sleeping
    wake_i = wk;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset", obs, {9'h1FF, 6'b000010});
    rst_n = 1'b1;
    fresh = 1'b1;
    model_init();
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[22];
  ctl_t none_c, rc;
  bit   wk;

  initial begin
    none_c = mkc(0, 0, 0, 0, 0, 9'h000);

    // Directed table: controls applied in the cycle, expected pc_o and mode of that cycle.
    vecs[0]  = mkv(1, 0, 0, 0, 0, 9'h055, 9'h1FF, M_FLUSH);  // goto ignored in flush
    vecs[1]  = mkv(0, 0, 0, 0, 0, 9'h000, 9'h000, M_RUN);
    vecs[2]  = mkv(1, 0, 0, 0, 0, 9'h0A5, 9'h001, M_RUN);    // goto 0A5
    vecs[3]  = mkv(0, 1, 0, 0, 0, 9'h1C3, 9'h0A5, M_FLUSH);  // call ignored in flush
    vecs[4]  = mkv(0, 1, 0, 0, 0, 9'h1C3, 9'h0A6, M_RUN);    // call: push 0A6, pc 0C3
    vecs[5]  = mkv(0, 0, 0, 0, 0, 9'h000, 9'h0C3, M_FLUSH);
    vecs[6]  = mkv(0, 0, 0, 0, 1, 9'h000, 9'h0C4, M_RUN);    // skip
    vecs[7]  = mkv(1, 0, 0, 0, 0, 9'h055, 9'h0C5, M_FLUSH);  // goto ignored in skip flush
    vecs[8]  = mkv(0, 0, 1, 0, 0, 9'h000, 9'h0C6, M_RUN);    // retlw -> 0A6
    vecs[9]  = mkv(0, 0, 0, 0, 0, 9'h000, 9'h0A6, M_FLUSH);
    vecs[10] = mkv(1, 1, 1, 0, 0, 9'h1AA, 9'h0A7, M_RUN);    // retlw wins, empty pop -> 000
    vecs[11] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h000, M_FLUSH);
    vecs[12] = mkv(1, 1, 0, 0, 0, 9'h1FE, 9'h001, M_RUN);    // call beats goto -> 0FE
    vecs[13] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h0FE, M_FLUSH);
    vecs[14] = mkv(1, 0, 0, 0, 0, 9'h1FF, 9'h0FF, M_RUN);    // goto 1FF
    vecs[15] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h1FF, M_FLUSH);  // wraps to 000 in flush
    vecs[16] = mkv(0, 0, 0, 1, 1, 9'h000, 9'h000, M_RUN);    // skip beats sleep
    vecs[17] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h001, M_FLUSH);
    vecs[18] = mkv(1, 0, 0, 0, 0, 9'h1FE, 9'h002, M_RUN);
    vecs[19] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h1FE, M_FLUSH);
    vecs[20] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h1FF, M_RUN);    // wraps to 000 in run
    vecs[21] = mkv(0, 0, 0, 0, 0, 9'h000, 9'h000, M_RUN);

    apply_reset();
    for (int i = 0; i < 22; i++)
      do_cycle(vecs[i].ctl, vecs[i].exp_pc, vecs[i].exp_mode, $sformatf("vec%0d", i));

    // Nested calls: three pushes then three pops; return path 051, 0C4, 0C4.
    apply_reset();
    do_cycle(none_c, 9'h1FF, M_FLUSH, "nest_reset");
    do_cycle(mkc(1, 0, 0, 0, 0, 9'h020), 9'h000, M_RUN, "nest_goto");
    do_cycle(none_c, 9'h020, M_FLUSH, "nest_f0");
    do_cycle(mkc(0, 1, 0, 0, 0, 9'h1C3), 9'h021, M_RUN, "nest_call1");
    do_cycle(none_c, 9'h0C3, M_FLUSH, "nest_f1");
    do_cycle(mkc(0, 1, 0, 0, 0, 9'h050), 9'h0C4, M_RUN, "nest_call2");
    do_cycle(none_c, 9'h050, M_FLUSH, "nest_f2");
    do_cycle(mkc(0, 1, 0, 0, 0, 9'h070), 9'h051, M_RUN, "nest_call3");
    do_cycle(none_c, 9'h070, M_FLUSH, "nest_f3");
    do_cycle(mkc(0, 0, 1, 0, 0, 9'h000), 9'h071, M_RUN, "nest_ret1");
    do_cycle(none_c, 9'h051, M_FLUSH, "nest_r1");
    do_cycle(mkc(0, 0, 1, 0, 0, 9'h000), 9'h052, M_RUN, "nest_ret2");
    do_cycle(none_c, 9'h0C4, M_FLUSH, "nest_r2");
    do_cycle(mkc(0, 0, 1, 0, 0, 9'h000), 9'h0C5, M_RUN, "nest_ret3");
    do_cycle(none_c, 9'h0C4, M_FLUSH, "nest_r3");
    do_cycle(none_c, 9'h0C5, M_RUN, "nest_after");
`ifdef STACK_STATUS_EN
    check("nest_stk", W'({stk_level_o, stk_err_o}), W'({2'd0, 1'b1}));
`endif

    // SLEEP: 20 frozen clocks, then wake resumes straight into RUN.
    apply_reset();
    do_cycle(none_c, 9'h1FF, M_FLUSH, "slp_reset");
    do_cycle(mkc(0, 0, 0, 1, 0, 9'h000), 9'h000, M_RUN, "slp_enter");
    for (int i = 0; i < 20; i++) sleep_clock(9'h001, 1'b0, $sformatf("slp_hold%0d", i));
    sleep_clock(9'h001, 1'b1, "slp_wake");
    do_cycle(none_c, 9'h001, M_RUN, "slp_resume");
    do_cycle(none_c, 9'h002, M_RUN, "slp_next");

    // Reset during Q3 of a CALL cycle: immediate reset values, no push.
    apply_reset();
    do_cycle(none_c, 9'h1FF, M_FLUSH, "mrst_f");
    do_cycle(mkc(1, 0, 0, 0, 0, 9'h020), 9'h000, M_RUN, "mrst_goto");
    do_cycle(none_c, 9'h020, M_FLUSH, "mrst_f2");
    call_i = 1'b1; longk_i = 9'h1C3;
    check("mrst_q1", obs, exp_word(9'h021, M_RUN, 0, 1'b0));
    @(negedge clk);
    check("mrst_q2", obs, exp_word(9'h021, M_RUN, 1, 1'b0));
    @(negedge clk);
    check("mrst_q3", obs, exp_word(9'h021, M_RUN, 2, 1'b0));
    rst_n = 1'b0;
    #1;
    check("mrst_async", obs, {9'h1FF, 6'b000010});
`ifdef STACK_STATUS_EN
    check("mrst_level", W'(stk_level_o), W'(2'd0));
`endif
    apply_reset();
    do_cycle(none_c, 9'h1FF, M_FLUSH, "mrst_after_f");
    do_cycle(mkc(0, 0, 1, 0, 0, 9'h000), 9'h000, M_RUN, "mrst_retlw");
    do_cycle(none_c, 9'h000, M_FLUSH, "mrst_popped");   // 021 here would mean a push leaked
    do_cycle(none_c, 9'h001, M_RUN, "mrst_run");

    // Randomized traffic against the cycle-level model.
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      if (m_mode == M_SLEEP) begin
        wk = ($urandom_range(0, 3) == 0);
        sleep_clock(m_pc, wk, "rnd_sleep");
        if (wk) m_mode = M_RUN;
      end else begin
        rc.g  = ($urandom_range(0, 5) == 0);
        rc.c  = ($urandom_range(0, 6) == 0);
        rc.r  = ($urandom_range(0, 6) == 0);
        rc.s  = ($urandom_range(0, 7) == 0);
        rc.k  = ($urandom_range(0, 5) == 0);
        rc.wk = ($urandom_range(0, 3) == 0);
        rc.lk = PC_W'($urandom_range(0, PC_MOD - 1));
        do_cycle(rc, m_pc, m_mode, "rnd");
        model_step(rc);
      end
    end
`ifdef STACK_STATUS_EN
    check("rnd_stk", W'({stk_level_o, stk_err_o}), W'({m_level[1:0], m_err}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
